// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-array signals of the shared port.
interface mem_port_arbiter_if #(parameter int DBITS = 16, parameter int ABITS = 12);
  logic             ireq;
  logic [DBITS-1:0] iaddr;
  logic             ignt;
  logic             irvalid;
  logic [DBITS-1:0] idout;
  logic             dreq;
  logic             dwe;
  logic [DBITS-1:0] daddr;
  logic [DBITS-1:0] ddin;
  logic             dgnt;
  logic             drvalid;
  logic [DBITS-1:0] ddout;
  logic [ABITS-1:0] maddr;
  logic             mwe;
  logic [DBITS-1:0] mdin;
  logic [DBITS-1:0] mdout;
  modport slave (
    input  ireq, iaddr, dreq, dwe, daddr, ddin, mdout,
    output ignt, irvalid, idout, dgnt, drvalid, ddout, maddr, mwe, mdin
  );
  modport master (
    output ireq, iaddr, dreq, dwe, daddr, ddin, mdout,
    input  ignt, irvalid, idout, dgnt, drvalid, ddout, maddr, mwe, mdin
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read array between fetch and load/store with a starvation guard.
module mem_port_arbiter #(
  parameter int DBITS  = 16,
  parameter int ABITS  = 12,
  parameter int STARVE = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = STARVE > 0 ? $clog2(STARVE + 1) : 1;
  logic [SW-1:0] streak;
  logic dinr, force_i, ignt, dgnt, itag, dtag, doob, irvalid, drvalid;
  logic [DBITS-1:0] ihold, dhold, dval;
  assign dinr    = bus.daddr[DBITS-1:ABITS+1] == '0;
  assign force_i = STARVE != 0 && streak == SW'(STARVE);
  assign dgnt    = !reset && bus.dreq && (!dinr || !(bus.ireq && force_i));
  assign ignt    = !reset && bus.ireq && (!bus.dreq || !dinr || force_i);
  assign irvalid = itag && !reset;
  assign drvalid = dtag && !reset;
  assign dval    = doob ? DBITS'(16'hDEAD) : bus.mdout;
  assign bus.ignt    = ignt;
  assign bus.dgnt    = dgnt;
  assign bus.maddr   = (dgnt && dinr) ? bus.daddr[ABITS:1] : bus.iaddr[ABITS:1];
  assign bus.mwe     = dgnt && bus.dwe && dinr;
  assign bus.mdin    = bus.ddin;
  assign bus.irvalid = irvalid;
  assign bus.drvalid = drvalid;
  assign bus.idout   = reset ? '0 : (irvalid ? bus.mdout : ihold);
  assign bus.ddout   = reset ? '0 : (drvalid ? dval : dhold);
  always_ff @(posedge clk) begin
    if (reset || ignt || !bus.ireq) streak <= '0;
    else if (dgnt && dinr && streak != SW'(STARVE)) streak <= streak + 1'b1;
    if (reset) begin
      itag  <= 1'b0;
      dtag  <= 1'b0;
      doob  <= 1'b0;
      ihold <= '0;
      dhold <= '0;
    end else begin
      itag <= ignt;
      dtag <= dgnt && !bus.dwe;
      doob <= dgnt && !bus.dwe && !dinr;
      if (irvalid) ihold <= bus.mdout;
      if (drvalid) dhold <= dval;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors against a behavioural sync-read array.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] mem [0:4095];
  mem_port_arbiter_if #(.DBITS(16), .ABITS(12)) b0 ();
  mem_port_arbiter_if #(.DBITS(16), .ABITS(12)) b1 ();
  mem_port_arbiter #(.DBITS(16), .ABITS(12), .STARVE(4)) u0 (.clk(clk), .reset(reset), .bus(b0));
  mem_port_arbiter #(.DBITS(16), .ABITS(12), .STARVE(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (b0.mwe) mem[b0.maddr] <= b0.mdin;
    b0.mdout <= mem[b0.maddr];
  end
  assign b1.mdout = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    b0.ireq = 1'b1; b0.iaddr = 16'h0200; b0.dreq = 1'b1; b0.dwe = 1'b0; b0.daddr = 16'h0010; b0.ddin = '0;
    b1.ireq = 1'b1; b1.iaddr = 16'h0200; b1.dreq = 1'b1; b1.dwe = 1'b0; b1.daddr = 16'h0010; b1.ddin = '0;
    #1;
    check("rst_ignt", 32'(b0.ignt), 0);
    check("rst_dgnt", 32'(b0.dgnt), 0);
    check("rst_mwe", 32'(b0.mwe), 0);
    tick;
    check("rst2_grants", {30'd0, b0.ignt, b0.dgnt}, 0);
    tick;
    reset = 1'b0; b0.ireq = 1'b0; b0.dreq = 1'b0;
    #1;
    check("idle_irvalid", 32'(b0.irvalid), 0);
    check("idle_drvalid", 32'(b0.drvalid), 0);
    check("idle_idout", 32'(b0.idout), 0);
    check("idle_ddout", 32'(b0.ddout), 0);
    // preload word 0x100 through the store path
    b0.dreq = 1'b1; b0.dwe = 1'b1; b0.daddr = 16'h0200; b0.ddin = 16'h2345;
    #1;
    check("pre_mwe", 32'(b0.mwe), 1);
    check("pre_maddr", 32'(b0.maddr), 32'h100);
    tick;
    b0.dreq = 1'b0; b0.dwe = 1'b0; b0.ireq = 1'b1; b0.iaddr = 16'h0200;
    #1;
    check("f_ignt", 32'(b0.ignt), 1);
    check("f_dgnt", 32'(b0.dgnt), 0);
    check("f_maddr", 32'(b0.maddr), 32'h100);
    tick;
    b0.ireq = 1'b0;
    #1;
    check("f_irvalid", 32'(b0.irvalid), 1);
    check("f_idout", 32'(b0.idout), 32'h2345);
    tick;
    #1;
    check("f_irvalid_off", 32'(b0.irvalid), 0);
    check("f_idout_hold", 32'(b0.idout), 32'h2345);
    b0.dreq = 1'b1; b0.dwe = 1'b1; b0.daddr = 16'h0010; b0.ddin = 16'hBEEF;
    #1;
    check("st_dgnt", 32'(b0.dgnt), 1);
    check("st_mwe", 32'(b0.mwe), 1);
    check("st_maddr", 32'(b0.maddr), 32'h008);
    tick;
    b0.dwe = 1'b0;
    #1;
    check("st_drvalid", 32'(b0.drvalid), 0);
    check("ld_dgnt", 32'(b0.dgnt), 1);
    check("ld_mwe", 32'(b0.mwe), 0);
    tick;
    b0.dreq = 1'b0;
    #1;
    check("ld_drvalid", 32'(b0.drvalid), 1);
    check("ld_ddout", 32'(b0.ddout), 32'hBEEF);
    tick;
    #1;
    check("ld_drvalid_off", 32'(b0.drvalid), 0);
    check("ld_ddout_hold", 32'(b0.ddout), 32'hBEEF);
    b0.ireq = 1'b1; b0.iaddr = 16'h0200; b0.dreq = 1'b1; b0.dwe = 1'b0; b0.daddr = 16'h0010;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("ct_ignt%0d", k), 32'(b0.ignt), (k % 5 == 4) ? 1 : 0);
      check($sformatf("ct_dgnt%0d", k), 32'(b0.dgnt), (k % 5 == 4) ? 0 : 1);
      check($sformatf("s0_ignt%0d", k), 32'(b1.ignt), 0);
      tick;
    end
    b0.ireq = 1'b0; b0.dreq = 1'b0;
    tick;
    b0.ireq = 1'b1; b0.iaddr = 16'h0200; b0.dreq = 1'b1; b0.dwe = 1'b0; b0.daddr = 16'hFFF0;
    #1;
    check("oob_dgnt", 32'(b0.dgnt), 1);
    check("oob_ignt", 32'(b0.ignt), 1);
    check("oob_mwe", 32'(b0.mwe), 0);
    check("oob_maddr", 32'(b0.maddr), 32'h100);
    tick;
    b0.ireq = 1'b0; b0.dwe = 1'b1; b0.daddr = 16'hFE10; b0.ddin = 16'h1111;
    #1;
    check("oob_drvalid", 32'(b0.drvalid), 1);
    check("oob_ddout", 32'(b0.ddout), 32'hDEAD);
    check("oob_irvalid", 32'(b0.irvalid), 1);
    check("oob_idout", 32'(b0.idout), 32'h2345);
    check("oobst_dgnt", 32'(b0.dgnt), 1);
    check("oobst_mwe", 32'(b0.mwe), 0);
    tick;
    b0.dreq = 1'b0; b0.dwe = 1'b0;
    tick;
    b0.ireq = 1'b1; b0.iaddr = 16'h0200;
    #1;
    check("ra_ignt", 32'(b0.ignt), 1);
    tick;
    reset = 1'b1; b0.ireq = 1'b0;
    #1;
    check("ra_irvalid", 32'(b0.irvalid), 0);
    check("ra_idout", 32'(b0.idout), 0);
    tick;
    reset = 1'b0;
    #1;
    check("ra_irvalid_post", 32'(b0.irvalid), 0);
    check("ra_idout_post", 32'(b0.idout), 0);
    check("ra_ddout_post", 32'(b0.ddout), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
